// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package lsu_pkg;

  // Controller states; IDLE and DONE are the only request-accepting states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StAccess = 3'd1,
    StRmwRd  = 3'd2,
    StRmwWr  = 3'd3,
    StDone   = 3'd4
  } lsu_state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane steering for a 16-bit little-endian data port: load extraction
// with zero/sign extension, and byte merge for read-modify-write stores.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [15:0] rd_word_i,     // word returned by memory
  input  logic [15:0] merge_word_i,  // word captured during the RMW read
  input  logic [15:0] wdata_i,       // store data; byte stores use [7:0]
  input  logic        byte_sel_i,    // address bit 0
  input  logic        size_i,
  input  logic        sign_ext_i,
  output logic [15:0] load_data_o,
  output logic [15:0] merge_data_o
);

  logic [7:0] load_byte;

  // Select, extend and merge the addressed byte lane.
  always_comb begin
    load_byte = byte_sel_i ? rd_word_i[15:8] : rd_word_i[7:0];
    if (size_i == SIZE_WORD) begin
      load_data_o = rd_word_i;
    end else if (sign_ext_i) begin
      load_data_o = {{8{load_byte[7]}}, load_byte};
    end else begin
      load_data_o = {8'h00, load_byte};
    end

    merge_data_o = merge_word_i;
    if (byte_sel_i) begin
      merge_data_o[15:8] = wdata_i[7:0];
    end else begin
      merge_data_o[7:0] = wdata_i[7:0];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between a CPU port and a 16-bit word-addressed data memory.
// Byte stores are done as read-modify-write; misaligned word accesses are
// rejected without touching memory.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              size_q;
  logic              sext_q;

  logic              misaligned;
  lsu_state_e        accept_state;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  lsu_byte_lane u_byte_lane (
    .rd_word_i   (mem_read_data),
    .merge_word_i(merge_q),
    .wdata_i     (wdata_q),
    .byte_sel_i  (addr_q[0]),
    .size_i      (size_q),
    .sign_ext_i  (sext_q),
    .load_data_o (load_data),
    .merge_data_o(merge_data)
  );

  // Route a new request from the live CPU inputs.
  always_comb begin
    misaligned = (size == SIZE_WORD) && addr[0];
    if (misaligned) begin
      accept_state = StDone;
    end else if (we && (size == SIZE_BYTE)) begin
      accept_state = StRmwRd;
    end else begin
      accept_state = StAccess;
    end
  end

  // Controller FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= 1'b0;
      sext_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            state_q <= accept_state;
            busy_q  <= (accept_state != StDone);
            if (misaligned) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: begin
          if (!we_q) begin
            rdata_q <= load_data;
          end
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StRmwRd: begin
          merge_q <= mem_read_data;
          state_q <= StRmwWr;
          busy_q  <= 1'b1;
        end
        StRmwWr: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Memory strobes; gated by rst_n so a reset edge never commits a write.
  always_comb begin
    mem_read       = rst_n && (((state_q == StAccess) && !we_q) || (state_q == StRmwRd));
    mem_write      = rst_n && (((state_q == StAccess) && we_q) || (state_q == StRmwWr));
    mem_addr       = {addr_q[ADDR_W-1:1], 1'b0};
    mem_write_data = (state_q == StRmwWr) ? merge_data : wdata_q;
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign rdata        = rdata_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural word memory and a
// scoreboard of expected completions.
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic        size;
  logic        sign_ext;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        misalign_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_read_data;

  dmem_lsu #(
    .ADDR_W(16),
    .DATA_W(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .we            (we),
    .size          (size),
    .sign_ext      (sign_ext),
    .addr          (addr),
    .wdata         (wdata),
    .busy          (busy),
    .done          (done),
    .rdata         (rdata),
    .misalign_err  (misalign_err),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge.
  logic [15:0] mem [0:255];
  logic        load_en;
  logic [7:0]  load_idx;
  logic [15:0] load_val;
  assign mem_read_data = mem[mem_addr[8:1]];
  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_val;
    else if (mem_write) mem[mem_addr[8:1]] <= mem_write_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt = 0, wr_cnt = 0, ovl_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read && mem_write) ovl_cnt <= ovl_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single cycle and record its expected completion.
  task automatic issue(input logic w, input logic sz, input logic sx, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd, input logic exp_err,
                       input int exp_lat, output int start);
    exp_t e;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    start = cyc;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Wait (bounded) for done, then compare against the scoreboard head.
  task automatic wait_done(input string tag, input int start);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    while (!done && (cyc - start) < 10) begin
      @(posedge clk); #1;
    end
    check({tag, " latency"}, cyc - start, e.lat);
    check({tag, " rdata"}, {16'h0, rdata}, {16'h0, e.rdata});
    check({tag, " err"}, {31'h0, misalign_err}, {31'h0, e.err});
    @(posedge clk); #1;
  endtask

  int st, st2, rd0, wr0, dn0;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 1'b0; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    load_en = 1'b1; load_idx = 8'h10; load_val = 16'hA5F0;
    @(posedge clk); #1;
    load_en = 1'b0;
    @(posedge clk); #1;
    check("rst done", {31'h0, done}, 32'h0);
    check("rst rdata", {16'h0, rdata}, 32'h0);
    check("rst err", {31'h0, misalign_err}, 32'h0);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst strobes", {30'h0, mem_read, mem_write}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word load.
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'hA5F0, 1'b0, 2, st);
    check("wld busy", {31'h0, busy}, 32'h1);
    wait_done("wld", st);
    check("wld reads", rd_cnt - rd0, 1);
    check("wld writes", wr_cnt - wr0, 0);

    // Byte loads, both lanes.
    issue(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0, 16'hFFA5, 1'b0, 2, st);
    wait_done("bld_hi_sx", st);
    issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h00F0, 1'b0, 2, st);
    wait_done("bld_lo_zx", st);

    // Byte store to the high lane; rdata holds the last load.
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 1'b0, 1'b0, 16'h0021, 16'h1234, 16'h00F0, 1'b0, 3, st);
    wait_done("bst_hi", st);
    check("bst_hi reads", rd_cnt - rd0, 1);
    check("bst_hi writes", wr_cnt - wr0, 1);
    check("bst_hi mem", {16'h0, mem[8'h10]}, 32'h34F0);
    issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h34F0, 1'b0, 2, st);
    wait_done("wld_after_bst", st);

    // Misaligned word load: no strobes, error with zero data.
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 1'b1, 1'b0, 16'h0023, 16'h0, 16'h0000, 1'b1, 1, st);
    wait_done("misal", st);
    check("misal strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);

    // Word store then byte store into the low lane.
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 1'b1, 1'b0, 16'h0022, 16'hBEEF, 16'h0000, 1'b0, 2, st);
    wait_done("wst", st);
    check("wst reads", rd_cnt - rd0, 0);
    check("wst mem", {16'h0, mem[8'h11]}, 32'hBEEF);
    issue(1'b1, 1'b0, 1'b0, 16'h0022, 16'h0077, 16'h0000, 1'b0, 3, st);
    wait_done("bst_lo", st);
    check("bst_lo mem", {16'h0, mem[8'h11]}, 32'hBE77);

    // Reset while in RMW_WR: write suppressed, operation abandoned.
    wr0 = wr_cnt; dn0 = done_cnt;
    req = 1'b1; we = 1'b1; size = 1'b0; sign_ext = 1'b0; addr = 16'h0020; wdata = 16'h0099;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("rstwr pre_write", {31'h0, mem_write}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstwr gated", {31'h0, mem_write}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rstwr busy", {31'h0, busy}, 32'h0);
    check("rstwr rdata", {16'h0, rdata}, 32'h0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rstwr mem", {16'h0, mem[8'h10]}, 32'h34F0);
    check("rstwr writes", wr_cnt - wr0, 0);
    check("rstwr dones", done_cnt - dn0, 0);

    // req held high: second request is sampled in DONE.
    rd0 = rd_cnt; dn0 = done_cnt;
    issue(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h34F0, 1'b0, 2, st);
    req = 1'b1;
    sb.push_back('{rdata: 16'h34F0, err: 1'b0, lat: 2});
    wait_done("held_1", st);
    req = 1'b0;
    st2 = st + 2;
    wait_done("held_2", st2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("held reads", rd_cnt - rd0, 2);
    check("held dones", done_cnt - dn0, 2);

    check("strobe overlap", ovl_cnt, 0);
    check("sb drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, word width; only 16 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have CPU-side inputs: req (1, request), we (1, 1=store), size (1, 0=byte 1=word), sign_ext (1, byte-load sign extend), addr (ADDR_W, byte address), wdata (DATA_W, store data; byte stores use [7:0]).
REQ-006 SHALL have CPU-side outputs: busy (1), done (1, one-cycle completion pulse), rdata (DATA_W, load result), misalign_err (1, valid with done).
REQ-007 SHALL have memory-side outputs: mem_addr (ADDR_W), mem_write_data (DATA_W), mem_write (1), mem_read (1).
REQ-008 SHALL have memory-side input mem_read_data (DATA_W); the memory reads combinationally and writes on the clock edge.

Function
REQ-009 SHALL implement states IDLE, ACCESS, RMW_RD, RMW_WR, DONE.
REQ-010 SHALL accept a request when req=1 in IDLE or DONE, latching addr, wdata, we, size and sign_ext.
REQ-011 SHALL drive busy=1 exactly in ACCESS, RMW_RD and RMW_WR, and SHALL ignore req while busy.
REQ-012 SHALL route an aligned word access (size=1, addr[0]=0) and any byte load to ACCESS.
REQ-013 SHALL route a byte store to RMW_RD, then to RMW_WR.
REQ-014 SHALL route a misaligned word access (size=1, addr[0]=1) directly to DONE with misalign_err=1 and rdata=0, asserting no memory strobe.
REQ-015 SHALL drive mem_addr = {latched addr[ADDR_W-1:1], 1'b0} whenever a strobe is asserted.
REQ-016 SHALL, in ACCESS, assert mem_read for a load or mem_write with mem_write_data=wdata for a word store.
REQ-017 SHALL, in RMW_RD, assert mem_read and capture mem_read_data into an internal merge register.
REQ-018 SHALL, in RMW_WR, assert mem_write with the merge word: addr[0]=0 replaces [7:0] with wdata[7:0]; addr[0]=1 replaces [15:8].
REQ-019 SHALL use little-endian byte lanes for byte loads: addr[0]=0 selects [7:0], addr[0]=1 selects [15:8]; the byte is zero-extended, or sign-extended when sign_ext=1.
REQ-020 SHALL register rdata at the end of the ACCESS cycle for loads; rdata holds until the next load completes.
REQ-021 SHALL pulse done for exactly the DONE cycle; DONE returns to IDLE unless a new request is accepted in that cycle.
REQ-022 SHALL have latency from request cycle N to done: word access and byte load at N+2, byte store at N+3, misaligned access at N+1.
REQ-023 SHALL never assert mem_read and mem_write in the same cycle.
REQ-024 SHALL deassert both strobes in IDLE and DONE.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, set state=IDLE, done=0, rdata=0, misalign_err=0 and clear the merge register.
REQ-026 SHALL gate mem_write and mem_read combinationally with rst_n, so no memory write occurs at a reset edge that interrupts a write state.
REQ-027 SHALL abandon an interrupted operation silently, with no done pulse.

Structure
REQ-028 SHALL place the state encoding and the SIZE_BYTE/SIZE_WORD constants in shared package lsu_pkg.
REQ-029 SHALL put byte-lane extract, extend and merge logic in one combinational sub-module, lsu_byte_lane.

Verification (memory word 0x10, byte address 0x0020, preloaded 0xA5F0)
REQ-030 SHALL cover a word load at 0x0020 requested in cycle 0 -> done in cycle 2, rdata=0xA5F0, misalign_err=0.
REQ-031 SHALL cover byte loads: 0x0021 with sign_ext=1 -> rdata=0xFFA5; 0x0020 with sign_ext=0 -> rdata=0x00F0.
REQ-032 SHALL cover a byte store at 0x0021 with wdata=0x1234 -> one read then one write of 0x34F0, done in cycle 3; a following word load returns 0x34F0.
REQ-033 SHALL cover a word load at 0x0023 -> done in cycle 1, misalign_err=1, rdata=0, no strobe asserted.
REQ-034 SHALL cover rst_n=0 during RMW_WR -> mem_write=0 that cycle, memory unchanged, state IDLE, no done pulse.
REQ-035 SHALL cover req held high through busy -> exactly one access per request; a request sampled in DONE starts the next access in the following cycle.
